// File: rtl/stopwatch_10hz.sv
// Stopwatch core: counts M:SS.t in BCD on a 10 Hz enable, with start/stop, clear and lap freeze.
// Latency: button edges and ticks act at the CLK edge that samples them; outputs are registered or a pure register mux.
// Backpressure: none; TICK_10HZ and button edges are consumed unconditionally every cycle.
//
// Ports:
//   CLK, RESETN            system clock, asynchronous active-low reset
//   TICK_10HZ              one-cycle count enable
//   START_STOP/CLEAR/LAP   debounced button levels, acted on at their rising edge
//   DIGITS                 {min, sec_tens, sec_units, tenths} BCD, or the frozen lap value
//   RUNNING, LAP_ACTIVE    status flags
//   OVERFLOW               limit reached: sticky when WRAP=0, one-cycle pulse when WRAP=1
module stopwatch_10hz #(
  parameter int unsigned MAX_MIN = 9,
  parameter bit          WRAP    = 1'b0
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        TICK_10HZ,
  input  logic        START_STOP,
  input  logic        CLEAR,
  input  logic        LAP,
  output logic [15:0] DIGITS,
  output logic        RUNNING,
  output logic        LAP_ACTIVE,
  output logic        OVERFLOW
);

  localparam logic [3:0] MAX_MIN_D = 4'(MAX_MIN);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  min_q, min_d;
  logic [3:0]  sec_tens_q, sec_tens_d;
  logic [3:0]  sec_units_q, sec_units_d;
  logic [3:0]  tenths_q, tenths_d;
  logic [15:0] lap_q, lap_d;
  logic        lap_active_q, lap_active_d;
  logic        ovf_q, ovf_d;
  logic        ss_prev_q, clr_prev_q, lap_prev_q;

  logic        ss_evt, clr_evt, lap_evt;
  logic        at_limit;
  logic [15:0] count_bcd;

  assign ss_evt  = START_STOP & ~ss_prev_q;
  assign clr_evt = CLEAR      & ~clr_prev_q;
  assign lap_evt = LAP        & ~lap_prev_q;

  assign count_bcd = {min_q, sec_tens_q, sec_units_q, tenths_q};
  assign at_limit  = (min_q == MAX_MIN_D) && (sec_tens_q == 4'd5) &&
                     (sec_units_q == 4'd9) && (tenths_q == 4'd9);

  always_comb begin
    state_d      = state_q;
    min_d        = min_q;
    sec_tens_d   = sec_tens_q;
    sec_units_d  = sec_units_q;
    tenths_d     = tenths_q;
    lap_d        = lap_q;
    lap_active_d = lap_active_q;
    ovf_d        = ovf_q;

    if (clr_evt) begin
      // Clear dominates everything else sampled at this edge.
      state_d      = ST_IDLE;
      min_d        = 4'd0;
      sec_tens_d   = 4'd0;
      sec_units_d  = 4'd0;
      tenths_d     = 4'd0;
      lap_active_d = 1'b0;
      ovf_d        = 1'b0;
    end else begin
      // In wrap mode the overflow flag is only a pulse for the wrapping cycle.
      if (WRAP) ovf_d = 1'b0;

      // Counting uses the registered state, so a start press in the same
      // cycle as a tick does not count that tick.
      if ((state_q == ST_RUN) && TICK_10HZ) begin
        if (at_limit) begin
          ovf_d = 1'b1;
          if (WRAP) begin
            min_d       = 4'd0;
            sec_tens_d  = 4'd0;
            sec_units_d = 4'd0;
            tenths_d    = 4'd0;
          end else begin
            state_d = ST_PAUSED;
          end
        end else if (tenths_q != 4'd9) begin
          tenths_d = tenths_q + 4'd1;
        end else begin
          tenths_d = 4'd0;
          if (sec_units_q != 4'd9) begin
            sec_units_d = sec_units_q + 4'd1;
          end else begin
            sec_units_d = 4'd0;
            if (sec_tens_q != 4'd5) begin
              sec_tens_d = sec_tens_q + 4'd1;
            end else begin
              sec_tens_d = 4'd0;
              // Not at limit here, so min_q < MAX_MIN.
              min_d = min_q + 4'd1;
            end
          end
        end
      end

      // A saturated count can only be left through clear or reset.
      if (ss_evt && !(ovf_q && !WRAP)) begin
        case (state_q)
          ST_IDLE:   state_d = ST_RUN;
          ST_RUN:    state_d = ST_PAUSED;
          ST_PAUSED: state_d = ST_RUN;
          default:   state_d = ST_IDLE;
        endcase
      end

      // Lap captures the value currently on display, before any increment.
      if (lap_evt && (state_q != ST_IDLE)) begin
        if (!lap_active_q) begin
          lap_d        = count_bcd;
          lap_active_d = 1'b1;
        end else begin
          lap_active_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q      <= ST_IDLE;
      min_q        <= 4'd0;
      sec_tens_q   <= 4'd0;
      sec_units_q  <= 4'd0;
      tenths_q     <= 4'd0;
      lap_q        <= 16'h0000;
      lap_active_q <= 1'b0;
      ovf_q        <= 1'b0;
      ss_prev_q    <= 1'b0;
      clr_prev_q   <= 1'b0;
      lap_prev_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      min_q        <= min_d;
      sec_tens_q   <= sec_tens_d;
      sec_units_q  <= sec_units_d;
      tenths_q     <= tenths_d;
      lap_q        <= lap_d;
      lap_active_q <= lap_active_d;
      ovf_q        <= ovf_d;
      ss_prev_q    <= START_STOP;
      clr_prev_q   <= CLEAR;
      lap_prev_q   <= LAP;
    end
  end

  assign DIGITS     = lap_active_q ? lap_q : count_bcd;
  assign RUNNING    = (state_q == ST_RUN);
  assign LAP_ACTIVE = lap_active_q;
  assign OVERFLOW   = ovf_q;

endmodule

// File: tb/tb_stopwatch_10hz.sv
module tb_stopwatch_10hz;

  logic CLK = 1'b0;
  logic RESETN = 1'b0;
  logic TICK_10HZ = 1'b0;
  logic START_STOP = 1'b0;
  logic CLEAR = 1'b0;
  logic LAP = 1'b0;

  logic [15:0] dig  [3];
  logic        run  [3];
  logic        lapa [3];
  logic        ovf  [3];

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  // Instance 0: defaults (9:59.9, saturate). 1: 1:59.9 saturate. 2: 1:59.9 wrap.
  stopwatch_10hz u_dut0 (
    .CLK(CLK), .RESETN(RESETN), .TICK_10HZ(TICK_10HZ), .START_STOP(START_STOP),
    .CLEAR(CLEAR), .LAP(LAP), .DIGITS(dig[0]), .RUNNING(run[0]),
    .LAP_ACTIVE(lapa[0]), .OVERFLOW(ovf[0]));
  stopwatch_10hz #(.MAX_MIN(1), .WRAP(1'b0)) u_dut1 (
    .CLK(CLK), .RESETN(RESETN), .TICK_10HZ(TICK_10HZ), .START_STOP(START_STOP),
    .CLEAR(CLEAR), .LAP(LAP), .DIGITS(dig[1]), .RUNNING(run[1]),
    .LAP_ACTIVE(lapa[1]), .OVERFLOW(ovf[1]));
  stopwatch_10hz #(.MAX_MIN(1), .WRAP(1'b1)) u_dut2 (
    .CLK(CLK), .RESETN(RESETN), .TICK_10HZ(TICK_10HZ), .START_STOP(START_STOP),
    .CLEAR(CLEAR), .LAP(LAP), .DIGITS(dig[2]), .RUNNING(run[2]),
    .LAP_ACTIVE(lapa[2]), .OVERFLOW(ovf[2]));

  // Reference model: elapsed time as an integer number of tenths.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2;
  int limit [3] = '{5999, 1199, 1199};
  bit wrp   [3] = '{1'b0, 1'b0, 1'b1};
  int m_cnt [3];
  int m_st  [3];
  bit m_lapa[3];
  int m_lapv[3];
  bit m_ovf [3];
  bit p_ss, p_clr, p_lap;

  function automatic logic [15:0] to_bcd(input int c);
    logic [3:0] mn, st, su, tt;
    mn = 4'(c / 600);
    st = 4'((c % 600) / 100);
    su = 4'((c % 100) / 10);
    tt = 4'(c % 10);
    return {mn, st, su, tt};
  endfunction

  function automatic logic [15:0] exp_dig(input int i);
    return m_lapa[i] ? to_bcd(m_lapv[i]) : to_bcd(m_cnt[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_st[i] = M_IDLE; m_lapa[i] = 0; m_lapv[i] = 0; m_ovf[i] = 0;
    end
    p_ss = 0; p_clr = 0; p_lap = 0;
  endtask

  task automatic model_step(input bit t, input bit s, input bit c, input bit l);
    bit se, ce, le;
    se = s & ~p_ss; ce = c & ~p_clr; le = l & ~p_lap;
    for (int i = 0; i < 3; i++) begin
      int ncnt, nst;
      bit novf;
      if (ce) begin
        m_cnt[i] = 0; m_st[i] = M_IDLE; m_lapa[i] = 0; m_ovf[i] = 0;
      end else begin
        ncnt = m_cnt[i]; nst = m_st[i]; novf = wrp[i] ? 1'b0 : m_ovf[i];
        if (m_st[i] == M_RUN && t) begin
          if (m_cnt[i] == limit[i]) begin
            novf = 1;
            if (wrp[i]) ncnt = 0;
            else nst = M_PAUSED;
          end else begin
            ncnt = m_cnt[i] + 1;
          end
        end
        if (se && !(m_ovf[i] && !wrp[i]))
          nst = (m_st[i] == M_RUN) ? M_PAUSED : M_RUN;
        if (le && m_st[i] != M_IDLE) begin
          if (!m_lapa[i]) begin
            m_lapv[i] = m_cnt[i]; m_lapa[i] = 1;
          end else begin
            m_lapa[i] = 0;
          end
        end
        m_cnt[i] = ncnt; m_st[i] = nst; m_ovf[i] = novf;
      end
    end
    p_ss = s; p_clr = c; p_lap = l;
  endtask

  // Drive inputs from a falling edge, clock them in, return at the next falling edge.
  task automatic cyc(input bit t, input bit s, input bit c, input bit l);
    TICK_10HZ = t; START_STOP = s; CLEAR = c; LAP = l;
    @(posedge CLK);
    model_step(t, s, c, l);
    @(negedge CLK);
  endtask

  task automatic apply_reset();
    TICK_10HZ = 0; START_STOP = 0; CLEAR = 0; LAP = 0;
    RESETN = 0;
    repeat (2) @(negedge CLK);
    RESETN = 1;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (dig[0] !== 16'h0000) begin failures++; $display("FAIL reset_digits: got %h want 0000", dig[0]); end
    checks++; if (run[0] !== 1'b0) begin failures++; $display("FAIL reset_running: got %b want 0", run[0]); end
    checks++; if (lapa[0] !== 1'b0) begin failures++; $display("FAIL reset_lap: got %b want 0", lapa[0]); end
    checks++; if (ovf[0] !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b want 0", ovf[0]); end
  endtask

  task automatic test_count();
    cyc(0, 1, 0, 0);
    repeat (25) cyc(1, 0, 0, 0);
    checks++; if (dig[0] !== 16'h0025) begin failures++; $display("FAIL count_25: got %h want 0025", dig[0]); end
    checks++; if (run[0] !== 1'b1) begin failures++; $display("FAIL count_running: got %b want 1", run[0]); end
  endtask

  task automatic test_minute_and_hold();
    repeat (574) cyc(1, 0, 0, 0);
    checks++; if (dig[0] !== 16'h0599) begin failures++; $display("FAIL at_0599: got %h want 0599", dig[0]); end
    cyc(1, 0, 0, 0);
    checks++; if (dig[0] !== 16'h1000) begin failures++; $display("FAIL minute_carry: got %h want 1000", dig[0]); end
    cyc(0, 1, 0, 0);
    checks++; if (run[0] !== 1'b0) begin failures++; $display("FAIL pause: got %b want 0", run[0]); end
    cyc(0, 0, 0, 0);
    repeat (5) cyc(1, 0, 0, 0);
    checks++; if (dig[0] !== 16'h1000) begin failures++; $display("FAIL paused_ticks: got %h want 1000", dig[0]); end
    repeat (1000) cyc(0, 1, 0, 0);
    checks++; if (run[0] !== 1'b1) begin failures++; $display("FAIL held_toggle: got %b want 1", run[0]); end
    cyc(1, 0, 0, 0);
    checks++; if (dig[0] !== 16'h1001) begin failures++; $display("FAIL held_then_tick: got %h want 1001", dig[0]); end
  endtask

  task automatic test_limit();
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    repeat (1199) cyc(1, 0, 0, 0);
    checks++; if (dig[1] !== 16'h1599) begin failures++; $display("FAIL sat_at_limit: got %h want 1599", dig[1]); end
    cyc(1, 0, 0, 0);
    checks++; if (dig[1] !== 16'h1599) begin failures++; $display("FAIL sat_hold: got %h want 1599", dig[1]); end
    checks++; if (ovf[1] !== 1'b1) begin failures++; $display("FAIL sat_ovf: got %b want 1", ovf[1]); end
    checks++; if (run[1] !== 1'b0) begin failures++; $display("FAIL sat_running: got %b want 0", run[1]); end
    checks++; if (dig[2] !== 16'h0000) begin failures++; $display("FAIL wrap_digits: got %h want 0000", dig[2]); end
    checks++; if (ovf[2] !== 1'b1) begin failures++; $display("FAIL wrap_ovf_pulse: got %b want 1", ovf[2]); end
    checks++; if (run[2] !== 1'b1) begin failures++; $display("FAIL wrap_running: got %b want 1", run[2]); end
    checks++; if (dig[0] !== 16'h2000) begin failures++; $display("FAIL default_2min: got %h want 2000", dig[0]); end
    cyc(0, 0, 0, 0);
    checks++; if (ovf[2] !== 1'b0) begin failures++; $display("FAIL wrap_ovf_one_cycle: got %b want 0", ovf[2]); end
    checks++; if (ovf[1] !== 1'b1) begin failures++; $display("FAIL sat_ovf_sticky: got %b want 1", ovf[1]); end
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    checks++; if (run[1] !== 1'b0) begin failures++; $display("FAIL sat_start_ignored: got %b want 0", run[1]); end
    checks++; if (dig[1] !== 16'h1599) begin failures++; $display("FAIL sat_start_hold: got %h want 1599", dig[1]); end
    cyc(0, 0, 1, 0);
    checks++; if (dig[1] !== 16'h0000) begin failures++; $display("FAIL sat_clear_digits: got %h want 0000", dig[1]); end
    checks++; if (ovf[1] !== 1'b0) begin failures++; $display("FAIL sat_clear_ovf: got %b want 0", ovf[1]); end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_lap();
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    checks++; if (lapa[0] !== 1'b0) begin failures++; $display("FAIL lap_in_idle: got %b want 0", lapa[0]); end
    cyc(0, 1, 0, 0);
    repeat (34) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    checks++; if (lapa[0] !== 1'b1) begin failures++; $display("FAIL lap_set: got %b want 1", lapa[0]); end
    repeat (12) cyc(1, 0, 0, 0);
    checks++; if (dig[0] !== 16'h0034) begin failures++; $display("FAIL lap_frozen: got %h want 0034", dig[0]); end
    cyc(0, 0, 0, 1);
    checks++; if (dig[0] !== 16'h0046) begin failures++; $display("FAIL lap_release: got %h want 0046", dig[0]); end
    checks++; if (lapa[0] !== 1'b0) begin failures++; $display("FAIL lap_cleared: got %b want 0", lapa[0]); end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_same_cycle();
    cyc(1, 1, 1, 0);
    checks++; if (dig[0] !== 16'h0000) begin failures++; $display("FAIL clr_prio_digits: got %h want 0000", dig[0]); end
    checks++; if (run[0] !== 1'b0) begin failures++; $display("FAIL clr_prio_running: got %b want 0", run[0]); end
    cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    checks++; if (run[0] !== 1'b1) begin failures++; $display("FAIL idle_start_tick_run: got %b want 1", run[0]); end
    checks++; if (dig[0] !== 16'h0000) begin failures++; $display("FAIL idle_start_tick_cnt: got %h want 0000", dig[0]); end
    cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    checks++; if (dig[0] !== 16'h0001) begin failures++; $display("FAIL run_stop_tick_cnt: got %h want 0001", dig[0]); end
    checks++; if (run[0] !== 1'b0) begin failures++; $display("FAIL run_stop_tick_run: got %b want 0", run[0]); end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    cyc(0, 1, 0, 0);
    repeat (7) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    TICK_10HZ = 0; START_STOP = 0; CLEAR = 0; LAP = 0;
    #2 RESETN = 0;
    #1;
    checks++; if (dig[0] !== 16'h0000) begin failures++; $display("FAIL async_digits: got %h want 0000", dig[0]); end
    checks++; if (run[0] !== 1'b0 || lapa[0] !== 1'b0 || ovf[0] !== 1'b0) begin
      failures++; $display("FAIL async_flags: got run=%b lap=%b ovf=%b want 0 0 0", run[0], lapa[0], ovf[0]);
    end
    @(negedge CLK);
    RESETN = 1;
    model_reset();
    repeat (5) cyc(1, 0, 0, 0);
    checks++; if (dig[0] !== 16'h0000 || run[0] !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle: got %h run=%b want 0000 run=0", dig[0], run[0]);
    end
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    checks++; if (dig[0] !== 16'h0001) begin failures++; $display("FAIL post_reset_count: got %h want 0001", dig[0]); end
  endtask

  task automatic test_random();
    bit t, s, c, l;
    s = 0; c = 0; l = 0;
    for (int n = 0; n < 6000; n++) begin
      t = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) s = ~s;
      if ($urandom_range(0, 29) == 0) l = ~l;
      c = ($urandom_range(0, 2999) == 0);
      cyc(t, s, c, l);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (dig[i] !== exp_dig(i) || run[i] !== (m_st[i] == M_RUN) ||
            lapa[i] !== m_lapa[i] || ovf[i] !== m_ovf[i]) begin
          failures++;
          $display("FAIL random dut%0d cyc%0d: got dig=%h run=%b lap=%b ovf=%b want dig=%h run=%b lap=%b ovf=%b",
                   i, n, dig[i], run[i], lapa[i], ovf[i], exp_dig(i), (m_st[i] == M_RUN), m_lapa[i], m_ovf[i]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    @(negedge CLK);
    test_reset();
    test_count();
    test_minute_and_hold();
    test_limit();
    test_lap();
    test_same_cycle();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
